dm_responder: RTL and testbench
===============================

// Module: dm_responder
// PURPOSE
//  Data-memory responder: the memory end of the CPU's DM port (DM_Address/DM_enable/DM_Write_Data/DM_Read_Data).
//  Stores are posted into a FIFO write buffer. Loads are served from the buffer, or from a slow external
//  req/ack memory bus. A DM_stall output lets the next-revision CPU freeze its PC while a load miss or a
//  full buffer is outstanding.
// PARAMETERS
//  ADDR_W    16  word address width (matches DM_Address)
//  DATA_W    32  data word width
//  WB_DEPTH  4   write-buffer entries; must be a power of 2
//  WB_AW     2   log2(WB_DEPTH)
// PORTS
//  clk            in   1       clock; all state updates on rising edge
//  rst            in   1       synchronous reset, active-low
//  DM_Address     in   ADDR_W  CPU word address
//  DM_enable      in   1       CPU store request
//  DM_read        in   1       CPU load request (CPU MemtoReg)
//  DM_Write_Data  in   DATA_W  store data
//  DM_Read_Data   out  DATA_W  load data returned to CPU
//  DM_stall       out  1       CPU must hold all DM_* inputs and its PC while high
//  ext_req        out  1       external bus request
//  ext_we         out  1       1 = write, 0 = read
//  ext_addr       out  ADDR_W  external word address
//  ext_wdata      out  DATA_W  external write data
//  ext_ack        in   1       one-cycle completion pulse
//  ext_rdata      in   DATA_W  read data, valid in the cycle ext_ack=1
// BEHAVIOUR
//  Reset (rst=0 at edge):
//   - FSM -> IDLE; buffer emptied (pending writes discarded); rd_data reg = 0.
//   - ext_req=0, ext_we=0, ext_addr=0, ext_wdata=0 from the next cycle.
//   - DM_stall=0 and DM_Read_Data=0 while rst=0.
//   - Reset mid-handshake drops ext_req; a late ext_ack is ignored.
//  Write buffer: circular FIFO of {addr,data}; count 0..WB_DEPTH; pointers wrap modulo WB_DEPTH.
//   - Store accepted: DM_enable=1, DM_read=0, not full -> push at edge; DM_stall=0.
//   - full=1 and DM_enable=1 -> DM_stall=1 (combinational on full). Push happens in the first cycle full=0.
//     A pop in the same cycle does not release the stall early.
//   - DM_enable and DM_read both 1: store is performed, load ignored, DM_Read_Data=0.
//  Load (DM_read=1):
//   - Hit: any valid entry address == DM_Address -> DM_Read_Data = youngest matching entry. Same cycle, DM_stall=0.
//   - Miss: handled by the FSM; DM_stall=1 until RD_DONE.
//   - DM_Read_Data=0 when there is no hit and the FSM is not in RD_DONE.
//  External bus rules:
//   - ext_req, ext_we, ext_addr and ext_wdata are registered.
//   - They stay stable from ext_req rise until the edge where ext_ack=1 is sampled.
//   - ext_req drops in the cycle after the ack; at least one idle cycle between requests.
//  FSM
//   IDLE:    if DM_read & miss     -> RD_REQ: load ext_addr=DM_Address, ext_we=0, ext_req=1.
//            elif count>0          -> WR_REQ: load ext_* from buffer head, ext_we=1.
//            Load misses take priority over drain.
//   RD_REQ:  on ext_ack, capture ext_rdata into rd_data and go to RD_DONE.
//   RD_DONE: DM_Read_Data=rd_data, DM_stall=0; go to IDLE unconditionally.
//   WR_REQ:  on ext_ack, pop head and go to IDLE. A load arriving here stalls; it is re-evaluated in IDLE
//            (a popped entry is then in memory).
//  Latency:
//   - Store: 0 CPU stall cycles unless full.
//   - Load hit: 0 stall cycles.
//   - Load miss from IDLE: stall = 1 + cycles in RD_REQ through ack; data is returned in RD_DONE.
// TESTING
//  1 rst=0 two cycles with DM_enable=1 -> ext_req=0, DM_stall=0, no push; after release count=0.
//  2 Store 0x0010<-0xDEADBEEF; ack 2 cycles after req -> ext_we=1, addr=0x0010, wdata held until ack; DM_stall never 1.
//  3 Five back-to-back stores, ext_ack held 0 -> 5th store sees DM_stall=1; it is pushed in the cycle after the first ack.
//  4 Store 0x20<-0x1, store 0x20<-0x2, load 0x20 (ack held 0) -> DM_Read_Data=0x2 same cycle, no ext read issued.
//  5 Empty buffer, load 0x40, ack on 3rd RD_REQ cycle with 0xCAFEF00D -> stall 4 cycles, then 0xCAFEF00D with stall=0.
//  6 rst=0 during RD_REQ, ack arrives after -> ext_req=0 next cycle; ack ignored; FSM IDLE, DM_Read_Data=0.

Source files
------------

// File: rtl/dm_responder.sv
// dm_responder: memory-side end of the CPU data-memory port.
// Stores are posted into a small circular write buffer that drains to a slow
// req/ack external bus. Loads are served from the buffer when the address is
// pending there. Otherwise they go to the external bus, and DM_stall holds
// the CPU until the data comes back.
module dm_responder #(
    parameter int ADDR_W   = 16,
    parameter int DATA_W   = 32,
    parameter int WB_DEPTH = 4,
    parameter int WB_AW    = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] DM_Address,
    input  logic              DM_enable,
    input  logic              DM_read,
    input  logic [DATA_W-1:0] DM_Write_Data,
    output logic [DATA_W-1:0] DM_Read_Data,
    output logic              DM_stall,
    output logic              ext_req,
    output logic              ext_we,
    output logic [ADDR_W-1:0] ext_addr,
    output logic [DATA_W-1:0] ext_wdata,
    input  logic              ext_ack,
    input  logic [DATA_W-1:0] ext_rdata
);

    // The occupancy counter needs one extra bit to represent "full".
    localparam int CW = WB_AW + 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_REQ  = 2'd1,
        RD_DONE = 2'd2,
        WR_REQ  = 2'd3
    } state_t;

    state_t state_q, state_d;

    // Write buffer storage. Only the head/tail/count control state is reset.
    logic [ADDR_W-1:0] wb_addr_q [WB_DEPTH];
    logic [DATA_W-1:0] wb_data_q [WB_DEPTH];
    logic [WB_AW-1:0]  head_q;
    logic [WB_AW-1:0]  tail_q;
    logic [CW-1:0]     count_q;

    // External bus registers and the captured load-miss data.
    logic              ext_req_q, ext_req_d;
    logic              ext_we_q, ext_we_d;
    logic [ADDR_W-1:0] ext_addr_q, ext_addr_d;
    logic [DATA_W-1:0] ext_wdata_q, ext_wdata_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;

    logic              full;
    logic              push;
    logic              pop;
    logic              load_req;
    logic              hit;
    logic [DATA_W-1:0] hit_data;
    logic [WB_AW-1:0]  idx;

    assign full     = (count_q == CW'(WB_DEPTH));
    // A store always wins over a simultaneous load.
    assign load_req = DM_read && !DM_enable;
    // A pop in the same cycle does not make room, because full is taken from
    // the registered count.
    assign push     = rst && DM_enable && !full;
    assign pop      = (state_q == WR_REQ) && ext_ack;

    assign ext_req   = ext_req_q;
    assign ext_we    = ext_we_q;
    assign ext_addr  = ext_addr_q;
    assign ext_wdata = ext_wdata_q;

    // Buffer lookup. Entries are scanned oldest to youngest, so the last
    // match (the youngest one) supplies the data.
    always_comb begin
        hit      = 1'b0;
        hit_data = '0;
        idx      = '0;
        for (int k = 0; k < WB_DEPTH; k++) begin
            idx = head_q + WB_AW'(k);
            if ((CW'(k) < count_q) && (wb_addr_q[idx] == DM_Address)) begin
                hit      = 1'b1;
                hit_data = wb_data_q[idx];
            end
        end
    end

    // CPU-facing response: read data and stall, both forced low during reset.
    always_comb begin
        DM_Read_Data = '0;
        DM_stall     = 1'b0;
        if (rst) begin
            if (DM_enable) begin
                DM_stall = full;
            end else begin
                if (DM_read && hit) begin
                    DM_Read_Data = hit_data;
                end else if (state_q == RD_DONE) begin
                    DM_Read_Data = rd_data_q;
                end
                if (DM_read && !hit && (state_q != RD_DONE)) begin
                    DM_stall = 1'b1;
                end
            end
        end
    end

    // Bus sequencer next state. A load miss is launched before any drain;
    // the bus registers only change when a request starts or is acknowledged.
    always_comb begin
        state_d     = state_q;
        ext_req_d   = ext_req_q;
        ext_we_d    = ext_we_q;
        ext_addr_d  = ext_addr_q;
        ext_wdata_d = ext_wdata_q;
        rd_data_d   = rd_data_q;
        case (state_q)
            IDLE: begin
                if (load_req && !hit) begin
                    state_d     = RD_REQ;
                    ext_req_d   = 1'b1;
                    ext_we_d    = 1'b0;
                    ext_addr_d  = DM_Address;
                    ext_wdata_d = '0;
                end else if (count_q != '0) begin
                    state_d     = WR_REQ;
                    ext_req_d   = 1'b1;
                    ext_we_d    = 1'b1;
                    ext_addr_d  = wb_addr_q[head_q];
                    ext_wdata_d = wb_data_q[head_q];
                end
            end
            RD_REQ: begin
                if (ext_ack) begin
                    rd_data_d = ext_rdata;
                    ext_req_d = 1'b0;
                    state_d   = RD_DONE;
                end
            end
            RD_DONE: begin
                state_d = IDLE;
            end
            WR_REQ: begin
                if (ext_ack) begin
                    ext_req_d = 1'b0;
                    state_d   = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Control and bus registers with synchronous active-low reset.
    // Reset also discards any pending buffer entries.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            head_q      <= '0;
            tail_q      <= '0;
            count_q     <= '0;
            ext_req_q   <= 1'b0;
            ext_we_q    <= 1'b0;
            ext_addr_q  <= '0;
            ext_wdata_q <= '0;
            rd_data_q   <= '0;
        end else begin
            state_q     <= state_d;
            ext_req_q   <= ext_req_d;
            ext_we_q    <= ext_we_d;
            ext_addr_q  <= ext_addr_d;
            ext_wdata_q <= ext_wdata_d;
            rd_data_q   <= rd_data_d;
            if (push) begin
                tail_q <= tail_q + WB_AW'(1);
            end
            if (pop) begin
                head_q <= head_q + WB_AW'(1);
            end
            count_q <= count_q + CW'(push) - CW'(pop);
        end
    end

    // Write buffer payload, written at the tail on an accepted store.
    always_ff @(posedge clk) begin
        if (push) begin
            wb_addr_q[tail_q] <= DM_Address;
            wb_data_q[tail_q] <= DM_Write_Data;
        end
    end

endmodule

// File: tb/tb_dm_responder.sv
// Bench for dm_responder. Directed stimulus pushes expected load data and
// expected bus writes into queues. A negedge monitor pops and compares them
// whenever the DUT completes a load or an external write.
module tb_dm_responder;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] DM_Address = '0;
    logic        DM_enable = 1'b0;
    logic        DM_read = 1'b0;
    logic [31:0] DM_Write_Data = '0;
    logic [31:0] DM_Read_Data;
    logic        DM_stall;
    logic        ext_req;
    logic        ext_we;
    logic [15:0] ext_addr;
    logic [31:0] ext_wdata;
    logic        ext_ack = 1'b0;
    logic [31:0] ext_rdata = '0;

    typedef struct {
        logic [15:0] a;
        logic [31:0] d;
    } wr_t;

    wr_t         exp_wr_q[$];
    logic [31:0] exp_rd_q[$];

    int          checks = 0;
    int          errors = 0;
    int          ack_delay = -1;
    bit          ack_now = 1'b0;
    int          req_age = 0;
    logic [31:0] rd_value = '0;
    int          rd_req_cyc = 0;

    always #5 clk = ~clk;

    dm_responder #(
        .ADDR_W(16), .DATA_W(32), .WB_DEPTH(4), .WB_AW(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .DM_Address(DM_Address),
        .DM_enable(DM_enable),
        .DM_read(DM_read),
        .DM_Write_Data(DM_Write_Data),
        .DM_Read_Data(DM_Read_Data),
        .DM_stall(DM_stall),
        .ext_req(ext_req),
        .ext_we(ext_we),
        .ext_addr(ext_addr),
        .ext_wdata(ext_wdata),
        .ext_ack(ext_ack),
        .ext_rdata(ext_rdata)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    // External memory model: an ack a fixed number of cycles after req rises,
    // or a single forced pulse on request.
    always @(posedge clk) begin
        #2;
        ext_ack = 1'b0;
        if (ack_now) begin
            ext_ack   = 1'b1;
            ext_rdata = rd_value;
            ack_now   = 1'b0;
            req_age   = 0;
        end else if (ext_req && ack_delay >= 0) begin
            if (req_age >= ack_delay) begin
                ext_ack   = 1'b1;
                ext_rdata = rd_value;
                req_age   = 0;
            end else begin
                req_age++;
            end
        end else begin
            req_age = 0;
        end
    end

    // Monitor: completed loads and acknowledged bus writes.
    always @(negedge clk) begin
        if (rst) begin
            if (DM_read && !DM_enable && !DM_stall) begin
                if (exp_rd_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL rd_unexpected actual=0x%0h required=none", DM_Read_Data);
                end else begin
                    chk("rd_data", 64'(DM_Read_Data), 64'(exp_rd_q.pop_front()));
                end
            end
            if (ext_req && !ext_we) rd_req_cyc++;
            if (ext_req && ext_ack && ext_we) begin
                if (exp_wr_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL wr_unexpected actual=0x%0h required=none", ext_addr);
                end else begin
                    wr_t e;
                    e = exp_wr_q.pop_front();
                    chk("wr_addr", 64'(ext_addr), 64'(e.a));
                    chk("wr_data", 64'(ext_wdata), 64'(e.d));
                end
            end
        end
    end

    task automatic store(input logic [15:0] a, input logic [31:0] d);
        wr_t e;
        DM_enable     = 1'b1;
        DM_read       = 1'b0;
        DM_Address    = a;
        DM_Write_Data = d;
        e.a = a;
        e.d = d;
        exp_wr_q.push_back(e);
    endtask

    task automatic wait_drain(input string name, input int budget);
        for (int i = 0; i < budget && exp_wr_q.size() != 0; i++) cyc();
        chk(name, 64'(exp_wr_q.size()), 64'h0);
        cyc();
    endtask

    // Load miss from an idle FSM: counts stall cycles and checks the bus read.
    task automatic miss_load(input string tag, input logic [15:0] a, input logic [31:0] v,
                             input int delay, input int exp_stall);
        int stallc;
        int bad;
        bit got;
        stallc    = 0;
        bad       = 0;
        got       = 1'b0;
        ack_delay = delay;
        rd_value  = v;
        DM_enable = 1'b0;
        DM_read   = 1'b1;
        DM_Address = a;
        exp_rd_q.push_back(v);
        for (int i = 0; i < 20 && !got; i++) begin
            mid();
            if (DM_stall) begin
                stallc++;
                if (ext_req && (ext_addr !== a || ext_we !== 1'b0)) bad++;
                cyc();
            end else begin
                got = 1'b1;
                chk({tag, "_data"}, 64'(DM_Read_Data), 64'(v));
            end
        end
        chk({tag, "_got"}, 64'(got), 64'h1);
        chk({tag, "_stall_cycles"}, 64'(stallc), 64'(exp_stall));
        chk({tag, "_bus_read"}, 64'(bad), 64'h0);
        cyc();
        DM_read = 1'b0;
        mid();
        chk({tag, "_idle_rdata"}, 64'(DM_Read_Data), 64'h0);
        chk({tag, "_idle_req"}, 64'(ext_req), 64'h0);
        cyc();
    endtask

    initial begin
        int stall_seen;
        int reqc;
        int bad;
        int base;

        // Reset held with a store request present
        rst           = 1'b0;
        DM_enable     = 1'b1;
        DM_Address    = 16'h0099;
        DM_Write_Data = 32'h0000_1234;
        for (int i = 0; i < 2; i++) begin
            mid();
            chk("t1_req", 64'(ext_req), 64'h0);
            chk("t1_stall", 64'(DM_stall), 64'h0);
            chk("t1_rdata", 64'(DM_Read_Data), 64'h0);
            chk("t1_addr", 64'(ext_addr), 64'h0);
            chk("t1_wdata", 64'(ext_wdata), 64'h0);
            cyc();
        end
        rst       = 1'b1;
        DM_enable = 1'b0;
        for (int i = 0; i < 3; i++) begin
            mid();
            chk("t1_empty_noreq", 64'(ext_req), 64'h0);
            cyc();
        end

        // Single posted store drained to the bus, ack after two cycles
        ack_delay = 2;
        store(16'h0010, 32'hDEAD_BEEF);
        mid();
        chk("t2_store_stall", 64'(DM_stall), 64'h0);
        cyc();
        DM_enable  = 1'b0;
        stall_seen = 0;
        reqc       = 0;
        bad        = 0;
        for (int i = 0; i < 10; i++) begin
            mid();
            if (DM_stall) stall_seen++;
            if (ext_req) begin
                reqc++;
                if (ext_addr !== 16'h0010 || ext_wdata !== 32'hDEAD_BEEF || ext_we !== 1'b1) bad++;
            end
            cyc();
        end
        chk("t2_stall_seen", 64'(stall_seen), 64'h0);
        chk("t2_req_cycles", 64'(reqc), 64'h3);
        chk("t2_hold", 64'(bad), 64'h0);
        chk("t2_drained", 64'(exp_wr_q.size()), 64'h0);

        // Five back-to-back stores with the bus stalled
        ack_delay = -1;
        for (int i = 0; i < 4; i++) begin
            store(16'h0100 + 16'(i), 32'h0000_00A0 + 32'(i));
            mid();
            chk("t3_store_stall", 64'(DM_stall), 64'h0);
            cyc();
        end
        store(16'h0104, 32'h0000_00A4);
        mid();
        chk("t3_full_stall", 64'(DM_stall), 64'h1);
        cyc();
        ack_now = 1'b1;
        mid();
        chk("t3_stall_ack_cycle", 64'(DM_stall), 64'h1);
        cyc();
        mid();
        chk("t3_stall_release", 64'(DM_stall), 64'h0);
        cyc();
        DM_enable = 1'b0;
        ack_delay = 0;
        wait_drain("t3_drain", 60);

        // Load hit on the youngest of two pending stores to one address
        ack_delay = -1;
        base = rd_req_cyc;
        store(16'h0020, 32'h0000_0001);
        mid();
        cyc();
        store(16'h0020, 32'h0000_0002);
        mid();
        cyc();
        DM_enable  = 1'b0;
        DM_read    = 1'b1;
        DM_Address = 16'h0020;
        exp_rd_q.push_back(32'h0000_0002);
        mid();
        chk("t4_hit_data", 64'(DM_Read_Data), 64'h2);
        chk("t4_hit_stall", 64'(DM_stall), 64'h0);
        cyc();
        DM_read = 1'b0;
        for (int i = 0; i < 3; i++) cyc();
        chk("t4_no_ext_read", 64'(rd_req_cyc - base), 64'h0);
        // Store and load together: store wins, read data is zero
        store(16'h0030, 32'h0000_0077);
        DM_read = 1'b1;
        mid();
        chk("t4_both_rdata", 64'(DM_Read_Data), 64'h0);
        chk("t4_both_stall", 64'(DM_stall), 64'h0);
        cyc();
        DM_enable = 1'b0;
        DM_read   = 1'b0;
        ack_delay = 0;
        wait_drain("t4_drain", 40);

        // Load miss, ack on the third RD_REQ cycle
        miss_load("t5", 16'h0040, 32'hCAFE_F00D, 2, 4);

        // Reset in the middle of a read handshake, then a late ack
        ack_delay  = -1;
        rd_value   = 32'hBAD0_BAD0;
        DM_read    = 1'b1;
        DM_Address = 16'h0050;
        mid();
        chk("t6_miss_stall", 64'(DM_stall), 64'h1);
        cyc();
        mid();
        chk("t6_req", 64'(ext_req), 64'h1);
        cyc();
        rst = 1'b0;
        mid();
        chk("t6_rst_stall", 64'(DM_stall), 64'h0);
        chk("t6_rst_rdata", 64'(DM_Read_Data), 64'h0);
        cyc();
        rst     = 1'b1;
        DM_read = 1'b0;
        ack_now = 1'b1;
        mid();
        chk("t6_req_dropped", 64'(ext_req), 64'h0);
        cyc();
        mid();
        chk("t6_rdata_after", 64'(DM_Read_Data), 64'h0);
        chk("t6_req_after", 64'(ext_req), 64'h0);
        chk("t6_stall_after", 64'(DM_stall), 64'h0);
        cyc();
        miss_load("t6_followup", 16'h0060, 32'h6060_6060, 1, 3);

        chk("end_rd_queue", 64'(exp_rd_q.size()), 64'h0);
        chk("end_wr_queue", 64'(exp_wr_q.size()), 64'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
